// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequenced ALU-control block: ALUop and funct
// constants, 4-bit control codes, FSM state and latency-select types.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_MEMW  = 2'd0;
  localparam logic [1:0] OP_BEQ   = 2'd1;
  localparam logic [1:0] OP_RTYPE = 2'd2;
  localparam logic [1:0] OP_MEMH  = 2'd3;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_MUL = 6'h18;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] C_AND     = 4'd0;
  localparam logic [3:0] C_OR      = 4'd1;
  localparam logic [3:0] C_ADD     = 4'd2;
  localparam logic [3:0] C_ILLEGAL = 4'd3;
  localparam logic [3:0] C_DIV     = 4'd4;
  localparam logic [3:0] C_MUL     = 4'd5;
  localparam logic [3:0] C_SUB     = 4'd6;
  localparam logic [3:0] C_SLT     = 4'd7;
  localparam logic [3:0] C_SLL     = 4'd8;
  localparam logic [3:0] C_SRL     = 4'd9;
  localparam logic [3:0] C_XOR     = 4'd10;
  localparam logic [3:0] C_NOR     = 4'd11;
  localparam logic [3:0] C_MEMW    = 4'd12;
  localparam logic [3:0] C_MEMH    = 4'd13;

  typedef enum logic {IDLE, WAIT} state_e;

  // Which latency a multi-cycle op loads into the down-counter.
  typedef enum logic {LAT_MUL, LAT_DIV} lat_sel_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-stage to ALU-control handshake bundle. The master is the decode
// stage, the slave is the sequenced control block.
interface alu_ctrl_seq_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              addi;
  logic [CTRL_W-1:0] ctrl_out;
  logic              out_valid;
  logic              busy;
  logic              ex;

  modport master (
    output in_valid, alu_op, funct, addi,
    input  in_ready, ctrl_out, out_valid, busy, ex
  );

  modport slave (
    input  in_valid, alu_op, funct, addi,
    output in_ready, ctrl_out, out_valid, busy, ex
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of {alu_op, funct, addi} into a 4-bit control
// code, plus whether the op is multi-cycle and which latency it uses.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic       addi,
  output logic [3:0] code,
  output logic       is_multi,
  output lat_sel_e   lat_sel
);

  // NOTE: every output gets a default before any branch, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    code     = C_ILLEGAL;
    is_multi = 1'b0;
    lat_sel  = LAT_MUL;
    if (addi) begin
      code = C_ADD;
    end else begin
      case (alu_op)
        OP_MEMW: code = C_MEMW;
        OP_BEQ:  code = C_SUB;
        OP_MEMH: code = C_MEMH;
        default: begin
          case (funct)
            F_ADD: code = C_ADD;
            F_SUB: code = C_SUB;
            F_AND: code = C_AND;
            F_OR:  code = C_OR;
            F_SLT: code = C_SLT;
            F_SLL: code = C_SLL;
            F_SRL: code = C_SRL;
            F_XOR: code = C_XOR;
            F_NOR: code = C_NOR;
            F_MUL: begin
              code     = C_MUL;
              is_multi = 1'b1;
              lat_sel  = LAT_MUL;
            end
            F_DIV: begin
              code     = C_DIV;
              is_multi = 1'b1;
              lat_sel  = LAT_DIV;
            end
            default: code = C_ILLEGAL;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control sequencer: accepts decoded ops over valid/ready,
// holds mul/div codes for their programmed latency and flags illegal functs.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16,
  parameter int EN_MULTI = 1,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic             MULTI_ON = (EN_MULTI != 0);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CTRL_W-1:0] ctrl_q, ctrl_nx;
  logic              ov_q, ov_nx;
  logic              busy_q, busy_nx;
  logic              ex_q, ex_nx;

  logic [3:0] code;
  logic       is_multi;
  lat_sel_e   lat_sel;
  logic       in_ready;
  logic       accept;

  alu_ctrl_decode u_decode (
    .alu_op   (bus.alu_op),
    .funct    (bus.funct),
    .addi     (bus.addi),
    .code     (code),
    .is_multi (is_multi),
    .lat_sel  (lat_sel)
  );

  assign in_ready = (state == IDLE) && !rst && !flush;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ctrl_nx  = ctrl_q;
    ov_nx    = 1'b0;
    busy_nx  = busy_q;
    ex_nx    = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      ctrl_nx  = '0;
      busy_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_nx = CTRL_W'(code);
            if (is_multi && MULTI_ON) begin
              state_nx = WAIT;
              busy_nx  = 1'b1;
              cnt_nx   = (lat_sel == LAT_DIV) ? DIV_LOAD : MUL_LOAD;
            end else begin
              ov_nx = 1'b1;
              ex_nx = (code == C_ILLEGAL);
            end
          end
        end
        WAIT: begin
          // out_valid is registered, so it is raised one edge early: the
          // cycle the counter reaches 0 is the cycle the result is complete.
          if (cnt == '0) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
            ov_nx  = (cnt == CNT_W'(1));
          end
        end
        default: begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: reset is synchronous and sampled here, so it has priority over
  // flush and the handshake without entering any sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= '0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
      ex_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      ctrl_q <= ctrl_nx;
      ov_q   <= ov_nx;
      busy_q <= busy_nx;
      ex_q   <= ex_nx;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = busy_q;
  assign bus.ex        = ex_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench: two instances (multi-cycle enabled / disabled) share
// stimulus; each is compared cycle by cycle against a behavioural model.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       addi;

  int checks = 0;
  int errors = 0;

  alu_ctrl_seq_if #(.CTRL_W(4)) bus_a ();
  alu_ctrl_seq_if #(.CTRL_W(4)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.alu_op   = alu_op;
  assign bus_a.funct    = funct;
  assign bus_a.addi     = addi;
  assign bus_b.in_valid = in_valid;
  assign bus_b.alu_op   = alu_op;
  assign bus_b.funct    = funct;
  assign bus_b.addi     = addi;

  alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
                 .EN_MULTI(1), .CNT_W(5)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_a.slave)
  );

  alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
                 .EN_MULTI(0), .CNT_W(5)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Model state, index 0 = multi-cycle instance, 1 = single-cycle instance.
  int m_rem  [2];
  int m_ctrl [2];
  bit m_ov   [2];
  bit m_ex   [2];
  int fmap   [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input int op, input int fn, input bit ad,
                                     output int code, output bit multi, output int lat);
    multi = 1'b0;
    lat   = 1;
    if (ad)           code = 2;
    else if (op == 0) code = 12;
    else if (op == 1) code = 6;
    else if (op == 3) code = 13;
    else begin
      code = fmap.exists(fn) ? fmap[fn] : 3;
      if (fn == 'h18) begin multi = 1'b1; lat = MUL_LAT; end
      if (fn == 'h1A) begin multi = 1'b1; lat = DIV_LAT; end
    end
  endfunction

  task automatic model_step(input int i);
    int code, lat;
    bit multi;
    if (rst || flush) begin
      m_rem[i] = 0; m_ctrl[i] = 0; m_ov[i] = 1'b0; m_ex[i] = 1'b0;
    end else if (m_rem[i] > 0) begin
      m_rem[i]--; m_ov[i] = 1'b0; m_ex[i] = 1'b0;
    end else if (in_valid) begin
      ref_decode(int'(alu_op), int'(funct), addi, code, multi, lat);
      m_ctrl[i] = code;
      if (multi && i == 0) begin
        m_rem[i] = lat; m_ov[i] = 1'b0; m_ex[i] = 1'b0;
      end else begin
        m_ov[i] = 1'b1; m_ex[i] = (code == 3);
      end
    end else begin
      m_ov[i] = 1'b0; m_ex[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_ready(input int i);
    return 32'((m_rem[i] == 0) && !rst && !flush);
  endfunction

  function automatic logic [31:0] exp_ov(input int i);
    return 32'(m_ov[i] || (m_rem[i] == 1));
  endfunction

  // One clock: check in_ready before the edge, step the model, check outputs.
  task automatic tick();
    #1;
    check("a.in_ready", 32'(bus_a.in_ready), exp_ready(0));
    check("b.in_ready", 32'(bus_b.in_ready), exp_ready(1));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a.ctrl_out",  32'(bus_a.ctrl_out),  32'(m_ctrl[0]));
    check("a.out_valid", 32'(bus_a.out_valid), exp_ov(0));
    check("a.busy",      32'(bus_a.busy),      32'(m_rem[0] > 0));
    check("a.ex",        32'(bus_a.ex),        32'(m_ex[0]));
    check("b.ctrl_out",  32'(bus_b.ctrl_out),  32'(m_ctrl[1]));
    check("b.out_valid", 32'(bus_b.out_valid), exp_ov(1));
    check("b.busy",      32'(bus_b.busy),      32'(m_rem[1] > 0));
    check("b.ex",        32'(bus_b.ex),        32'(m_ex[1]));
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] fn, input bit ad);
    in_valid = v;
    alu_op   = op;
    funct    = fn;
    addi     = ad;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'd0, 6'h00, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [5:0] fn_pool [12];
  int         busy_cycles;
  int         ov_cycle;

  initial begin
    fmap['h20] = 2;  fmap['h22] = 6;  fmap['h24] = 0;  fmap['h25] = 1;
    fmap['h2A] = 7;  fmap['h18] = 5;  fmap['h1A] = 4;  fmap['h00] = 8;
    fmap['h02] = 9;  fmap['h26] = 10; fmap['h27] = 11;
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18,
                6'h1A, 6'h00, 6'h02, 6'h26, 6'h27, 6'h3F};
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_ctrl[i] = 0; m_ov[i] = 1'b0; m_ex[i] = 1'b0;
    end

    // Reset held two cycles with a valid op presented.
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 2'd2, 6'h20, 1'b0);
    tick(); tick();
    rst = 1'b0;
    idle(1);

    // Back-to-back single-cycle ops: add, sub, lw, addi.
    drive(1'b1, 2'd2, 6'h20, 1'b0); tick();
    drive(1'b1, 2'd2, 6'h22, 1'b0); tick();
    drive(1'b1, 2'd0, 6'h3F, 1'b0); tick();
    drive(1'b1, 2'd2, 6'h3F, 1'b1); tick();
    idle(2);

    // Illegal funct pulses ex for exactly one cycle.
    drive(1'b1, 2'd2, 6'h3F, 1'b0); tick();
    idle(2);

    // div with in_valid held during WAIT; count busy cycles and find out_valid.
    busy_cycles = 0;
    ov_cycle    = 0;
    drive(1'b1, 2'd2, 6'h1A, 1'b0); tick();
    if (bus_a.busy) busy_cycles++;
    for (int k = 2; k <= 20; k++) begin
      if (k <= 16) drive(1'b1, 2'd2, 6'h20, 1'b0);
      else         drive(1'b0, 2'd0, 6'h00, 1'b0);
      if (bus_a.out_valid && ov_cycle == 0) ov_cycle = k - 1;
      tick();
      if (bus_a.busy) busy_cycles++;
    end
    check("div.busy_cycles", 32'(busy_cycles), 32'(DIV_LAT));
    check("div.ov_cycle",    32'(ov_cycle),    32'(DIV_LAT));

    // mul: sequenced on instance a, single-cycle on instance b.
    drive(1'b1, 2'd2, 6'h18, 1'b0); tick();
    idle(MUL_LAT + 1);

    // mul accepted at N, flush at edge N+2.
    drive(1'b1, 2'd2, 6'h18, 1'b0); tick();
    idle(1);
    flush = 1'b1; tick(); flush = 1'b0;
    idle(1);

    // flush together with a valid op in IDLE: nothing accepted.
    flush = 1'b1;
    drive(1'b1, 2'd2, 6'h22, 1'b0); tick();
    flush = 1'b0;
    idle(1);

    // flush exactly on the counter==0 cycle of div.
    drive(1'b1, 2'd2, 6'h1A, 1'b0); tick();
    idle(DIV_LAT - 1);
    flush = 1'b1; tick(); flush = 1'b0;
    idle(1);

    // reset mid-WAIT.
    drive(1'b1, 2'd2, 6'h1A, 1'b0); tick();
    idle(5);
    rst = 1'b1; tick(); rst = 1'b0;
    idle(1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] fn;
      if ($urandom_range(0, 1) == 0) fn = fn_pool[$urandom_range(0, 11)];
      else                           fn = 6'($urandom_range(0, 63));
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), fn,
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) != 0) alu_op = 2'd2;
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU-control decoder.
- Accepts {ALUop, funct, addi} from the decode stage over a valid/ready handshake and emits the ALU control code.
- Sequences multi-cycle ops (mul, div): holds the code, raises busy and stalls issue until the programmed latency elapses.
- Flags illegal R-format functs with a one-cycle ex pulse and supports a synchronous flush from the hazard unit.

Parameters:
- CTRL_W, 4, width of ctrl_out; must be >= 4.
- MUL_LAT, 4, cycles mul occupies the ALU; must be >= 2.
- DIV_LAT, 16, cycles div occupies the ALU; must be >= 2.
- EN_MULTI, 1, 1 = mul/div sequenced with *_LAT; 0 = mul/div treated as single-cycle.
- CNT_W, 5, down-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the op in flight.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  block can accept an op; combinational: state==IDLE & !rst & !flush.
- alu_op  in  2  0 = lw/sw, 1 = beq, 2 = R-type, 3 = lh/sh.
- funct  in  6  R-type function field.
- addi  in  1  overrides alu_op/funct; selects add.
- ctrl_out  out  CTRL_W  registered ALU control code, zero-extended.
- out_valid  out  1  registered; ALU result for ctrl_out is complete this cycle.
- busy  out  1  registered; a multi-cycle op is in progress.
- ex  out  1  registered; illegal-op pulse, coincident with out_valid.

Behaviour:
Clock and reset:
- One clock: clk. Reset rst is synchronous and active-high.
- On reset: state=IDLE, counter=0, ctrl_out=0, out_valid=0, busy=0, ex=0. in_ready=0 while rst is high.

Decode:
- addi=1 -> code 2, regardless of other inputs.
- Otherwise by alu_op: 0 -> 12; 3 -> 13; 1 -> 6.
- alu_op=2, by funct: 0x20 add 2; 0x22 sub 6; 0x24 and 0; 0x25 or 1; 0x2A slt 7; 0x18 mul 5; 0x1A div 4; 0x00 sll 8; 0x02 srl 9; 0x26 xor 10; 0x27 nor 11; any other funct -> 3 (illegal).

State machine (IDLE, WAIT), accept = in_valid & in_ready at edge of cycle N:
- IDLE, single-cycle op: cycle N+1 ctrl_out=code, out_valid=1, ex=(code==3). State stays IDLE, so back-to-back accepts give one result per cycle.
- IDLE, no accept: out_valid=0, ex=0, ctrl_out holds its last value.
- IDLE, mul/div with EN_MULTI=1:
  - Cycle N+1: state=WAIT, ctrl_out=code, busy=1, counter=LAT-1.
  - Counter decrements once per cycle.
  - Cycle N+LAT (counter==0): out_valid=1.
  - Cycle N+LAT+1: state=IDLE, busy=0, out_valid=0.
  - First new accept is possible at the edge ending cycle N+LAT+1.
- WAIT: ctrl_out is stable throughout; in_ready=0; input values are ignored.
- ex only ever pulses for single-cycle illegal ops. mul/div never raise ex.

Flush and simultaneous events:
- flush=1 at edge M: cycle M+1 has state=IDLE, busy=0, out_valid=0, ex=0, counter=0, ctrl_out=0.
- flush beats in_valid in the same cycle; nothing is accepted.
- flush during the WAIT cycle with counter==0: out_valid is already visible in that cycle. Cycle M+1 is flushed as normal.
- rst beats flush and all other inputs.

Width rules:
- Codes are 4-bit constants zero-extended to CTRL_W.
- The counter never wraps: it loads only from IDLE and stops at 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUop encodings and funct constants.
  - Control-code constants: AND=0, OR=1, ADD=2, ILLEGAL=3, DIV=4, MUL=5, SUB=6, SLT=7, SLL=8, SRL=9, XOR=10, NOR=11, MEMW=12, MEMH=13.
  - State enum {IDLE, WAIT}.
- Sub-module alu_ctrl_decode: pure combinational {alu_op, funct, addi} -> {code, is_multi, lat_sel}. The top level holds the FSM, counter and output registers.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> in_ready=0, all outputs 0; first cycle after rst low, in_ready=1.
- Back-to-back: accept add(0x20), sub(0x22), lw(alu_op=0), addi on 4 consecutive edges -> ctrl_out=2,6,12,2 with out_valid=1 on cycles N+1..N+4; busy never set.
- Illegal: alu_op=2, funct=0x3F -> next cycle ctrl_out=3, out_valid=1, ex=1; one cycle later ex=0; in_ready stays 1.
- Multi-cycle: div (0x1A) with DIV_LAT=16 accepted at N -> busy=1 for N+1..N+16, out_valid only at N+16, ctrl_out=4 held; in_valid held high during WAIT -> no accept until edge N+17. Repeat mul with MUL_LAT=4 -> out_valid at N+4. With EN_MULTI=0, mul -> out_valid at N+1, busy=0.
- Flush: mul accepted at N, flush at edge N+2 -> cycle N+3 shows busy=0, out_valid=0, ctrl_out=0, in_ready=1. flush together with in_valid in IDLE -> no accept, out_valid=0 next cycle.
- Boundary: flush on the counter==0 cycle of div -> out_valid=1 that cycle, all outputs 0 next cycle. rst asserted mid-WAIT -> IDLE next cycle with all outputs 0.
